// File: rtl/cntb_issue_sequencer.sv
// cntb_issue_sequencer: X-IF issue/commit/result sequencer for the bit-count unit; `CNTB_SEQ_WATCHDOG_EN adds an EXEC watchdog.
module cntb_issue_sequencer #(
  parameter int          ID_WIDTH   = 4,
  parameter logic [6:0]  OPCODE     = 7'h0B,
  parameter int          MAX_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [31:0]         issue_rs0_i,
  input  logic [31:0]         issue_rs1_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                unit_start_o,
  output logic [31:0]         unit_rs0_o,
  output logic [31:0]         unit_rs1_o,
  input  logic                unit_done_i,
  input  logic [31:0]         unit_result_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic [31:0]         result_data_o,
  output logic                result_we_o,
  output logic                result_err_o
);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT_COMMIT, RESULT} state_t;
  state_t state_q, state_d;
  logic [ID_WIDTH-1:0] id_q;
  logic [4:0] rd_q;
  logic committed_q, killed_q;
  logic is_custom, take, hit_issue, hit_cur, done, timeout;
  assign is_custom         = issue_instr_i[6:0] == OPCODE;
  assign issue_ready_o     = state_q == IDLE;
  assign issue_accept_o    = issue_valid_i & is_custom;
  assign issue_writeback_o = issue_valid_i & is_custom;
  assign take              = issue_valid_i & issue_ready_o & is_custom;
  assign hit_issue         = commit_valid_i & (commit_id_i == issue_id_i);
  assign hit_cur           = commit_valid_i & (commit_id_i == id_q) & (state_q == EXEC | state_q == WAIT_COMMIT);
  assign done              = (state_q == EXEC) & (unit_done_i | timeout);
  assign result_valid_o    = state_q == RESULT;
  assign result_id_o       = id_q;
  assign result_rd_o       = rd_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        state_d = take ? EXEC : IDLE;
      EXEC:        if (done) state_d = (killed_q | (hit_cur & commit_kill_i)) ? IDLE :
                                       (committed_q | hit_cur) ? RESULT : WAIT_COMMIT;
      WAIT_COMMIT: if (hit_cur) state_d = commit_kill_i ? IDLE : RESULT;
      RESULT:      state_d = result_ready_i ? IDLE : RESULT;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      id_q          <= '0;
      rd_q          <= '0;
      committed_q   <= 1'b0;
      killed_q      <= 1'b0;
      unit_start_o  <= 1'b0;
      unit_rs0_o    <= '0;
      unit_rs1_o    <= '0;
      result_data_o <= '0;
      result_we_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_start_o <= take;
      if (take) begin
        id_q        <= issue_id_i;
        rd_q        <= issue_instr_i[11:7];
        result_we_o <= issue_instr_i[11:7] != 5'd0;
        unit_rs0_o  <= issue_rs0_i;
        unit_rs1_o  <= issue_rs1_i;
        committed_q <= hit_issue & ~commit_kill_i;
        killed_q    <= hit_issue & commit_kill_i;
      end else if (hit_cur) begin
        committed_q <= committed_q | ~commit_kill_i;
        killed_q    <= killed_q | commit_kill_i;
      end
      // a watchdog abort reports zero data
      if (done) result_data_o <= unit_done_i ? unit_result_i : '0;
    end
  end
`ifdef CNTB_SEQ_WATCHDOG_EN
  localparam int CW = $clog2(MAX_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic err_q;
  assign timeout      = cnt_q == CW'(MAX_CYCLES - 1);
  assign result_err_o = err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == EXEC) ? cnt_q + 1'b1 : '0;
      if (done) err_q <= ~unit_done_i;
    end
  end
`else
  logic unused_max;
  assign unused_max   = ^MAX_CYCLES;
  assign timeout      = 1'b0;
  assign result_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_cntb_issue_sequencer.sv
// tb_cntb_issue_sequencer: vector table plus scoreboard of expected results for cntb_issue_sequencer.
module tb_cntb_issue_sequencer;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic issue_valid = 1'b0, issue_ready_o, issue_accept_o, issue_writeback_o;
  logic [31:0] issue_instr = '0, issue_rs0 = '0, issue_rs1 = '0;
  logic [3:0] issue_id = '0, commit_id = '0, result_id_o;
  logic commit_valid = 1'b0, commit_kill = 1'b0;
  logic unit_start_o, unit_done = 1'b0;
  logic [31:0] unit_rs0_o, unit_rs1_o, unit_result = '0, result_data_o;
  logic result_valid_o, result_ready = 1'b0, result_we_o, result_err_o;
  logic [4:0] result_rd_o;
  int passed = 0, total = 0;

  typedef struct {
    logic [6:0] op; logic [4:0] rd; logic [3:0] id; logic [31:0] rs0; logic [4:0] rs1;
    int mode; logic kill; int dly; int hold;
  } vec_t;
  typedef struct {
    logic [3:0] id; logic [4:0] rd; logic [31:0] data; logic we; logic err;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[8];

  cntb_issue_sequencer #(.ID_WIDTH(4), .OPCODE(7'h0B), .MAX_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr),
    .issue_id_i(issue_id), .issue_rs0_i(issue_rs0), .issue_rs1_i(issue_rs1),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .unit_start_o(unit_start_o), .unit_rs0_o(unit_rs0_o), .unit_rs1_o(unit_rs1_o),
    .unit_done_i(unit_done), .unit_result_i(unit_result),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready), .result_id_o(result_id_o),
    .result_rd_o(result_rd_o), .result_data_o(result_data_o), .result_we_o(result_we_o),
    .result_err_o(result_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  always @(negedge clk) if (rst_ni && result_valid_o) check("unexpected_result", 32'(sb.size() != 0), 1);

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic take_result(input int hold);
    exp_t e;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", result_valid_o, 1);
      check("hold_data", result_data_o, sb[0].data);
      check("hold_id", result_id_o, sb[0].id);
      tick();
    end
    check("result_valid", result_valid_o, 1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    result_ready = 1'b1;
    check("result_id", result_id_o, e.id);
    check("result_rd", result_rd_o, e.rd);
    check("result_data", result_data_o, e.data);
    check("result_we", result_we_o, e.we);
    check("result_err", result_err_o, e.err);
    tick();
    result_ready = 1'b0;
    check("idle_after_result", issue_ready_o, 1);
    check("valid_dropped", result_valid_o, 0);
  endtask

  task automatic drive_issue(input logic [6:0] op, input logic [4:0] rd, input logic [3:0] id,
                             input logic [31:0] rs0, input logic [4:0] rs1);
    issue_valid = 1'b1;
    issue_instr = {20'h0, rd, op};
    issue_id    = id;
    issue_rs0   = rs0;
    issue_rs1   = {27'h0, rs1};
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  task automatic run_txn(input vec_t v);
    logic acc;
    acc = v.op == 7'h0B;
    drive_issue(v.op, v.rd, v.id, v.rs0, v.rs1);
    if (v.mode == 0) commit(v.id, v.kill);
    #1;
    check("issue_ready", issue_ready_o, 1);
    check("accept", issue_accept_o, acc);
    check("writeback", issue_writeback_o, acc);
    if (acc && !v.kill) sb.push_back('{v.id, v.rd, 32'($countones(v.rs0)), v.rd != 0, 1'b0});
    @(negedge clk);
    issue_valid = 1'b0; commit_valid = 1'b0; commit_kill = 1'b0;
    #1;
    check("start", unit_start_o, acc);
    if (!acc) begin
      check("ready_after_reject", issue_ready_o, 1);
      return;
    end
    check("unit_rs0", unit_rs0_o, v.rs0);
    check("unit_rs1", unit_rs1_o, 32'(v.rs1));
    if (v.mode == 1) commit(v.id, v.kill);
    repeat (v.dly) begin
      @(negedge clk);
      commit_valid = 1'b0; commit_kill = 1'b0;
      #1;
      check("start_pulse", unit_start_o, 0);
      check("exec_busy", issue_ready_o, 0);
    end
    unit_done = 1'b1;
    unit_result = 32'($countones(unit_rs0_o));
    tick();
    unit_done = 1'b0;
    if (v.mode == 2) begin
      check("wait_commit_hold", result_valid_o, 0);
      commit(v.id, v.kill);
      tick();
      commit_valid = 1'b0; commit_kill = 1'b0;
    end
    if (v.kill) begin
      check("killed_no_result", result_valid_o, 0);
      check("killed_idle", issue_ready_o, 1);
      return;
    end
    take_result(v.hold);
  endtask

  initial begin
    vecs[0] = '{7'h0B, 5'd5,  4'd3,  32'hF000_0000, 5'd31, 1, 1'b0, 3, 2};
    vecs[1] = '{7'h33, 5'd1,  4'd4,  32'h0000_00FF, 5'd0,  0, 1'b0, 1, 0};
    vecs[2] = '{7'h0B, 5'd7,  4'd2,  32'h0000_FFFF, 5'd3,  1, 1'b1, 5, 0};
    vecs[3] = '{7'h0B, 5'd0,  4'd5,  32'h1234_5678, 5'd7,  0, 1'b0, 1, 0};
    vecs[4] = '{7'h0B, 5'd31, 4'd15, 32'hFFFF_FFFF, 5'd1,  2, 1'b0, 2, 1};
    vecs[5] = '{7'h0B, 5'd9,  4'd6,  32'h0000_0000, 5'd2,  2, 1'b1, 1, 0};
    vecs[6] = '{7'h0B, 5'd12, 4'd0,  32'h8000_0001, 5'd4,  0, 1'b1, 2, 0};
    vecs[7] = '{7'h0F, 5'd3,  4'd1,  32'h0000_0001, 5'd0,  0, 1'b0, 1, 0};
    #1;
    check("rst_issue_ready", issue_ready_o, 1);
    check("rst_result_valid", result_valid_o, 0);
    check("rst_unit_start", unit_start_o, 0);
    check("rst_result_data", result_data_o, 0);
    check("rst_result_err", result_err_o, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    tick();
    foreach (vecs[i]) run_txn(vecs[i]);

    // wrong-id commits are ignored; an issue while busy is not taken
    drive_issue(7'h0B, 5'd10, 4'd1, 32'h0000_00A5, 5'd8);
    sb.push_back('{4'd1, 5'd10, 32'd4, 1'b1, 1'b0});
    tick();
    check("seqA_start", unit_start_o, 1);
    drive_issue(7'h0B, 5'd11, 4'd9, 32'hFFFF_FFFF, 5'd0);
    commit(4'd7, 1'b0);
    #1;
    check("seqA_busy_ready", issue_ready_o, 0);
    tick();
    issue_valid = 1'b0; commit_valid = 1'b0;
    check("seqA_no_restart", unit_start_o, 0);
    check("seqA_rs0_kept", unit_rs0_o, 32'h0000_00A5);
    unit_done = 1'b1; unit_result = 32'd4;
    tick();
    unit_done = 1'b0;
    check("seqA_wait", result_valid_o, 0);
    commit(4'd7, 1'b1);
    tick();
    commit_valid = 1'b0; commit_kill = 1'b0;
    check("seqA_still_wait", result_valid_o, 0);
    check("seqA_not_idle", issue_ready_o, 0);
    commit(4'd1, 1'b0);
    tick();
    commit_valid = 1'b0;
    take_result(0);

    // reset while a result is pending drops it
    drive_issue(7'h0B, 5'd4, 4'd8, 32'h0000_0003, 5'd1);
    commit(4'd8, 1'b0);
    sb.push_back('{4'd8, 5'd4, 32'd2, 1'b1, 1'b0});
    tick();
    issue_valid = 1'b0; commit_valid = 1'b0;
    unit_done = 1'b1; unit_result = 32'd2;
    tick();
    unit_done = 1'b0;
    check("seqB_result", result_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check("seqB_rst_valid", result_valid_o, 0);
    check("seqB_rst_ready", issue_ready_o, 1);
    check("seqB_rst_rd", result_rd_o, 0);
    check("seqB_rst_rs0", unit_rs0_o, 0);
    sb.delete();
    tick();
    rst_ni = 1'b1;
    tick();
    check("seqB_idle", issue_ready_o, 1);
    run_txn(vecs[0]);

`ifdef CNTB_SEQ_WATCHDOG_EN
    drive_issue(7'h0B, 5'd6, 4'd2, 32'h0000_000F, 5'd0);
    sb.push_back('{4'd2, 5'd6, 32'd0, 1'b1, 1'b1});
    tick();
    issue_valid = 1'b0;
    commit(4'd2, 1'b0);
    repeat (7) begin
      tick();
      commit_valid = 1'b0;
    end
    check("wd_before_limit", result_valid_o, 0);
    tick();
    take_result(0);
`endif
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/cntb_issue_sequencer.md
Name: cntb_issue_sequencer

Overview:
- Sequences the custom bit-count execution unit behind the CV-X-IF coprocessor port.
- Accepts one custom-opcode instruction at a time and forwards its operands to the multi-cycle unit with a start/done handshake.
- Tracks commit/kill for the in-flight instruction and returns the result over a valid/ready result channel carrying id, rd and data.
- Sits between the core's X-IF issue/commit/result signals and the count datapath.

Parameters:
- ID_WIDTH, 4: width of instruction id fields.
- OPCODE, 7'h0B: instr[6:0] value accepted as custom (custom-0).
- MAX_CYCLES, 64: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  sequencer can take an issue this cycle.
- issue_instr_i  in  32  instruction word.
- issue_id_i  in  ID_WIDTH  instruction id.
- issue_rs0_i  in  32  operand rs0.
- issue_rs1_i  in  32  operand rs1 (bit index, low 5 bits used).
- issue_accept_o  out  1  instruction accepted as custom; valid while issue_valid_i=1.
- issue_writeback_o  out  1  accepted instruction will write rd.
- commit_valid_i  in  1  commit strobe.
- commit_id_i  in  ID_WIDTH  id being committed.
- commit_kill_i  in  1  kill the committed id.
- unit_start_o  out  1  one-cycle start pulse to the count unit.
- unit_rs0_o  out  32  latched rs0.
- unit_rs1_o  out  32  latched rs1.
- unit_done_i  in  1  unit result valid, one-cycle pulse.
- unit_result_i  in  32  unit result.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  core takes result.
- result_id_o  out  ID_WIDTH  id of result.
- result_rd_o  out  5  destination register, instr[11:7].
- result_data_o  out  32  result value.
- result_we_o  out  1  1 when rd != 0.
- result_err_o  out  1  watchdog abort flag; 0 without the optional feature.

Behaviour:
- Reset: state IDLE; all registered outputs 0 (unit_*, result_*, latched id/rd, committed and killed flags). issue_ready_o = (state==IDLE), so it reads 1 during and after reset.
- Issue handshake fires when issue_valid_i & issue_ready_o.
  - issue_accept_o = issue_writeback_o = (instr[6:0]==OPCODE); combinational, 0 when issue_valid_i=0.
  - Non-matching opcode: handshake completes, accept=0, state unchanged.
  - Matching opcode: latch id, rd, rs0, rs1; go to EXEC; assert unit_start_o for exactly the first EXEC cycle.
- States:
  - IDLE -> EXEC on accepted issue.
  - EXEC -> on unit_done_i: capture unit_result_i. If killed -> IDLE, no result. Else if committed -> RESULT. Else -> WAIT_COMMIT.
  - WAIT_COMMIT -> RESULT on a matching commit with kill=0; -> IDLE on a matching commit with kill=1.
  - RESULT: result_valid_o=1, outputs held stable until result_ready_i=1, then -> IDLE. Latency to IDLE is 0 extra cycles: a new issue can be taken the next cycle.
- Commit matching:
  - A commit matches when commit_valid_i & commit_id_i==latched id, sampled in EXEC, WAIT_COMMIT and in the issue-accept cycle (compared against issue_id_i).
  - Non-matching commits are ignored.
  - A commit arriving in RESULT or IDLE is ignored.
  - A kill in EXEC cannot abort the unit: the sequencer waits for unit_done_i, discards the result, and drives no result_valid_o.
- unit_done_i outside EXEC is ignored.
- Reset mid-operation returns to IDLE immediately and drops any pending result.

Optional Feature:
- Macro CNTB_SEQ_WATCHDOG_EN.
- Defined: a cycle counter runs in EXEC. If unit_done_i is not seen within MAX_CYCLES cycles of unit_start_o, the sequencer leaves EXEC as if done, with data 0 and result_err_o=1. Commit/kill rules apply unchanged. A late unit_done_i is ignored.
- Undefined: no counter; EXEC waits indefinitely; result_err_o tied 0.

Test Plan:
- Issue instr opcode 0x0B, rd=5, id=3, rs0=0xF0000000, rs1=31; commit id 3 kill=0 one cycle later; unit_done with 4 after 3 cycles -> one unit_start pulse, result_valid with id=3 rd=5 data=4 we=1, held under result_ready=0 for 2 cycles, then IDLE.
- Issue opcode 0x33 -> accept=0, writeback=0, no unit_start, issue_ready stays 1.
- Issue id=2 then commit id=2 kill=1 during EXEC; done after 5 cycles -> no result_valid, back in IDLE, next issue accepted the following cycle.
- Commit id=7 (non-matching) then id=1 after done -> stays in WAIT_COMMIT until the id=1 commit, then result presented; commit in the same cycle as issue counts as committed.
- Assert rst_ni low in RESULT -> result_valid 0 immediately; state IDLE after release.
- Macro on, MAX_CYCLES=8, unit_done never asserted, commit kill=0 -> result_valid after 8 EXEC cycles with data=0, err=1.
